// File: rtl/xg_pon_frame_sync_aligner.sv
// XG-PON downstream frame synchroniser with bit alignment.
// Hunts for the 64-bit PSync pattern at any bit offset of an unaligned word
// stream. It runs the HUNT/PRESYNC/SYNC acquisition machine with M1/M2
// hysteresis. It emits frame-aligned words, a start-of-frame marker and the
// superframe counter taken from PSBd.
module xg_pon_frame_sync_aligner #(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned FRAME_WORDS = 19440,
  parameter logic [63:0] PSYNC       = 64'hC5E51840FD59BB49,
  parameter int unsigned M1          = 2,
  parameter int unsigned M2          = 3
) (
  input  logic                      clk_in,
  input  logic                      reset_in,
  input  logic [DATA_W-1:0]         rx_data_in,
  input  logic                      rx_valid_in,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_valid,
  output logic                      out_sof,
  output logic [50:0]               sfc_out,
  output logic                      sfc_valid,
  output logic [1:0]                sync_state,
  output logic [$clog2(DATA_W)-1:0] bit_offset,
  output logic                      sync_loss
);

  localparam int unsigned OFF_W    = $clog2(DATA_W);
  localparam int unsigned WIN_W    = 2 * DATA_W;
  localparam int unsigned PS_W     = 64;
  localparam int unsigned SFC_W    = 51;
  localparam int unsigned CNT_W    = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int unsigned DET_W    = $clog2(M1 + 1);
  localparam int unsigned MISS_W   = $clog2(M2 + 1);
  // With 64-bit words the SFC field arrives in the word after PSync.
  localparam bit          SFC_NEXT = (DATA_W == 64);
  localparam int unsigned SFC_SH   = SFC_NEXT ? 0 : PS_W;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PRESYNC = 2'd1,
    SYNC    = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [DATA_W-1:0] prev_word;
  logic [WIN_W-1:0]  window;
  logic [WIN_W-1:0]  win_shift;
  logic [DATA_W-1:0] cand;
  logic [DATA_W-1:0] sfc_word;
  logic              lock_hit;
  logic              hunt_hit;
  logic [OFF_W-1:0]  hunt_off;
  logic [CNT_W-1:0]  word_cnt;
  logic [DET_W-1:0]  det_cnt;
  logic [MISS_W-1:0] miss_cnt;
  logic              is_bnd;
  logic              boundary;
  logic              det_done;
  logic              miss_done;
  logic              sfc_pend;
  logic              sync_path;
  logic              sync_word_d;
  logic              out_sof_d;
  logic              sfc_valid_d;
  logic              sfc_pend_d;
  logic              sync_loss_d;

  // Alignment window and the candidate word at the locked offset
  assign window    = {prev_word, rx_data_in};
  assign win_shift = window << bit_offset;
  assign cand      = win_shift[WIN_W-1 -: DATA_W];
  assign sfc_word  = cand << SFC_SH;
  assign lock_hit  = (cand[DATA_W-1 -: PS_W] == PSYNC);
  assign is_bnd    = (word_cnt == '0);
  assign boundary  = rx_valid_in && is_bnd;
  assign det_done  = ((32'(det_cnt) + 32'd1) >= M1);
  assign miss_done = ((32'(miss_cnt) + 32'd1) >= M2);
  assign sync_state = state;

  // Full-offset PSync search; the lowest matching offset wins
  always_comb begin
    hunt_hit = 1'b0;
    hunt_off = '0;
    for (int k = DATA_W - 1; k >= 0; k--) begin
      if (window[WIN_W-1-k -: PS_W] == PSYNC) begin
        hunt_hit = 1'b1;
        hunt_off = OFF_W'(k);
      end
    end
  end

  // State register
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state <= HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  // Acquisition next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      HUNT: begin
        if (rx_valid_in && hunt_hit) begin
          state_nxt = PRESYNC;
        end
      end
      PRESYNC: begin
        if (boundary) begin
          if (!lock_hit) begin
            state_nxt = HUNT;
          end else if (det_done) begin
            state_nxt = SYNC;
          end
        end
      end
      SYNC: begin
        if (boundary && !lock_hit && miss_done) begin
          state_nxt = HUNT;
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  // Output decode: next values for the registered output stage
  always_comb begin
    sync_path   = (state == SYNC) || (state_nxt == SYNC);
    sync_word_d = rx_valid_in && sync_path;
    out_sof_d   = sync_word_d && is_bnd;
    sync_loss_d = (state == SYNC) && (state_nxt == HUNT);
    sfc_valid_d = out_sof_d;
    sfc_pend_d  = 1'b0;
    if (SFC_NEXT) begin
      sfc_valid_d = sync_word_d && sfc_pend;
      if (sync_path) begin
        sfc_pend_d = sync_word_d ? out_sof_d : sfc_pend;
      end
    end
  end

  // Word history, frame position, detection/miss counters and offset lock
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      prev_word  <= '0;
      word_cnt   <= '0;
      det_cnt    <= '0;
      miss_cnt   <= '0;
      bit_offset <= '0;
    end else if (rx_valid_in) begin
      prev_word <= rx_data_in;
      word_cnt  <= (word_cnt == LAST_WORD) ? '0 : word_cnt + 1'b1;
      case (state)
        HUNT: begin
          if (hunt_hit) begin
            bit_offset <= hunt_off;
            word_cnt   <= CNT_W'(1);
            det_cnt    <= DET_W'(1);
            miss_cnt   <= '0;
          end
        end
        PRESYNC: begin
          if (is_bnd && lock_hit) begin
            det_cnt <= det_cnt + 1'b1;
          end
        end
        SYNC: begin
          if (is_bnd) begin
            miss_cnt <= lock_hit ? '0 : miss_cnt + 1'b1;
          end
        end
        default: begin
          det_cnt <= '0;
        end
      endcase
    end
  end

  // Registered output stage
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      sfc_out   <= '0;
      sfc_valid <= 1'b0;
      sync_loss <= 1'b0;
      sfc_pend  <= 1'b0;
    end else begin
      out_valid <= sync_word_d;
      out_sof   <= out_sof_d;
      sfc_valid <= sfc_valid_d;
      sync_loss <= sync_loss_d;
      sfc_pend  <= sfc_pend_d;
      if (rx_valid_in) begin
        out_data <= cand;
      end
      if (sfc_valid_d) begin
        sfc_out <= sfc_word[DATA_W-1 -: SFC_W];
      end
    end
  end

endmodule

// File: tb/tb_xg_pon_frame_sync_aligner.sv
// Directed bench for xg_pon_frame_sync_aligner: 64-bit and 128-bit instances.
module tb_xg_pon_frame_sync_aligner;

  localparam logic [63:0] PSYNC = 64'hC5E51840FD59BB49;
  localparam int unsigned FW    = 16;

  logic         clk = 1'b0;
  logic         reset_in;
  logic [63:0]  d64;
  logic         v64;
  logic [127:0] d128;
  logic         v128;

  logic [63:0]  out_data64;
  logic         out_valid64, out_sof64, sfc_valid64, sync_loss64;
  logic [50:0]  sfc_out64;
  logic [1:0]   sync_state64;
  logic [5:0]   bit_offset64;

  logic [127:0] out_data128;
  logic         out_valid128, out_sof128, sfc_valid128, sync_loss128;
  logic [50:0]  sfc_out128;
  logic [1:0]   sync_state128;
  logic [6:0]   bit_offset128;

  int n_assert = 0;
  int n_fail   = 0;
  int n;
  int shift;
  int fb;
  int b;
  bit corrupt [0:63];

  always #5 clk = ~clk;

  xg_pon_frame_sync_aligner #(
    .DATA_W(64), .FRAME_WORDS(FW), .PSYNC(PSYNC), .M1(2), .M2(3)
  ) u_dut64 (
    .clk_in(clk), .reset_in(reset_in), .rx_data_in(d64), .rx_valid_in(v64),
    .out_data(out_data64), .out_valid(out_valid64), .out_sof(out_sof64),
    .sfc_out(sfc_out64), .sfc_valid(sfc_valid64), .sync_state(sync_state64),
    .bit_offset(bit_offset64), .sync_loss(sync_loss64)
  );

  xg_pon_frame_sync_aligner #(
    .DATA_W(128), .FRAME_WORDS(FW), .PSYNC(PSYNC), .M1(2), .M2(3)
  ) u_dut128 (
    .clk_in(clk), .reset_in(reset_in), .rx_data_in(d128), .rx_valid_in(v128),
    .out_data(out_data128), .out_valid(out_valid128), .out_sof(out_sof128),
    .sfc_out(sfc_out128), .sfc_valid(sfc_valid128), .sync_state(sync_state128),
    .bit_offset(bit_offset128), .sync_loss(sync_loss128)
  );

  // Aligned 64-bit frame stream: PSync, SFC word (SFC = 5 + frame), sparse payload
  function automatic logic [63:0] g64(input int idx);
    int f;
    int w;
    logic [63:0] word;
    if (idx < 0) return 64'h0;
    f = idx / 16;
    w = idx % 16;
    if (w == 0) begin
      word = PSYNC;
      if (corrupt[f]) word = word ^ 64'h1;
    end else if (w == 1) begin
      word = {51'(5 + f), 13'h0};
    end else begin
      word = {32'h0, 8'(f), 16'h0, 8'(w)};
    end
    return word;
  endfunction

  // Aligned stream delayed by s bits
  function automatic logic [63:0] sh64(input int idx, input int s);
    logic [127:0] pair;
    pair = {g64(idx - 1), g64(idx)} >> s;
    return pair[63:0];
  endfunction

  function automatic logic [127:0] g128(input int idx);
    int f;
    int w;
    f = idx / 16;
    w = idx % 16;
    if (w == 0) return {PSYNC, 51'(5 + f), 13'h0};
    return {96'h0, 8'(f), 16'h0, 8'(w)};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step64(input logic [63:0] d, input logic v);
    d64  = d;
    v64  = v;
    v128 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic step128(input logic [127:0] d, input logic v);
    d128 = d;
    v128 = v;
    v64  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send64_to(input int last);
    while (n <= last) begin
      step64(sh64(n, shift), 1'b1);
      n++;
    end
  endtask

  task automatic send128_to(input int last);
    while (n <= last) begin
      step128(g128(n), 1'b1);
      n++;
    end
  endtask

  task automatic do_reset();
    reset_in = 1'b1;
    v64      = 1'b0;
    v128     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_in = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_in = 1'b1;
    d64 = '0; v64 = 1'b0; d128 = '0; v128 = 1'b0;
    for (int i = 0; i < 64; i++) corrupt[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state64", sync_state64, 2'd0);
    check("rst_valid64", out_valid64, 1'b0);
    check("rst_sof64", out_sof64, 1'b0);
    check("rst_offset64", bit_offset64, 6'd0);
    check("rst_sfcv64", sfc_valid64, 1'b0);
    check("rst_loss64", sync_loss64, 1'b0);
    check("rst_data64", out_data64, 64'h0);
    check("rst_state128", sync_state128, 2'd0);
    check("rst_valid128", out_valid128, 1'b0);
    reset_in = 1'b0;

    // 1: clean frames at offset 0
    shift = 0; n = 0;
    send64_to(1);
    check("t1_presync", sync_state64, 2'd1);
    check("t1_offset", bit_offset64, 6'd0);
    check("t1_novalid", out_valid64, 1'b0);
    send64_to(16);
    check("t1_still_presync", sync_state64, 2'd1);
    check("t1_novalid2", out_valid64, 1'b0);
    send64_to(17);
    check("t1_sync", sync_state64, 2'd2);
    check("t1_first_valid", out_valid64, 1'b1);
    check("t1_first_sof", out_sof64, 1'b1);
    check("t1_sof_data", out_data64, PSYNC);
    check("t1_sfcv_early", sfc_valid64, 1'b0);
    send64_to(18);
    check("t1_sfcv", sfc_valid64, 1'b1);
    check("t1_sfc6", sfc_out64, 51'd6);
    check("t1_sof_off", out_sof64, 1'b0);
    send64_to(19);
    check("t1_sfcv_pulse", sfc_valid64, 1'b0);
    send64_to(33);
    check("t1_sof2", out_sof64, 1'b1);
    send64_to(34);
    check("t1_sfc7", sfc_out64, 51'd7);
    check("t1_sfcv2", sfc_valid64, 1'b1);

    // 2: same stream delayed by 17 bits
    do_reset();
    shift = 17; n = 0;
    send64_to(1);
    check("t2_presync", sync_state64, 2'd1);
    check("t2_offset", bit_offset64, 6'd17);
    send64_to(17);
    check("t2_sync", sync_state64, 2'd2);
    check("t2_sof", out_sof64, 1'b1);
    check("t2_sof_data", out_data64, PSYNC);
    while (n <= 40) begin
      step64(sh64(n, shift), 1'b1);
      check("t2_data", out_data64, g64(n - 1));
      check("t2_sof_pos", out_sof64, 1'((n % 16) == 1));
      n++;
    end

    // 3: random valid gaps while in SYNC
    repeat (80) begin
      if ($urandom_range(0, 1) == 1) begin
        step64(sh64(n, shift), 1'b1);
        check("t3_valid", out_valid64, 1'b1);
        check("t3_sof_pos", out_sof64, 1'((n % 16) == 1));
        check("t3_data", out_data64, g64(n - 1));
        n++;
      end else begin
        step64({$urandom, $urandom}, 1'b0);
        check("t3_gap_valid", out_valid64, 1'b0);
        check("t3_gap_sof", out_sof64, 1'b0);
      end
      check("t3_state", sync_state64, 2'd2);
      check("t3_loss", sync_loss64, 1'b0);
    end

    // 4: flywheel through two misses, then loss after three
    fb = n / 16 + 1;
    b  = 16 * fb + 1;
    corrupt[fb] = 1'b1;
    corrupt[fb + 1] = 1'b1;
    send64_to(b);
    check("t4_miss1_state", sync_state64, 2'd2);
    check("t4_miss1_sof", out_sof64, 1'b1);
    check("t4_miss1_data", out_data64, PSYNC ^ 64'h1);
    check("t4_miss1_loss", sync_loss64, 1'b0);
    send64_to(b + 16);
    check("t4_miss2_state", sync_state64, 2'd2);
    check("t4_miss2_sof", out_sof64, 1'b1);
    check("t4_miss2_loss", sync_loss64, 1'b0);
    send64_to(b + 32);
    check("t4_clean_state", sync_state64, 2'd2);
    check("t4_clean_data", out_data64, PSYNC);
    corrupt[fb + 3] = 1'b1;
    corrupt[fb + 4] = 1'b1;
    corrupt[fb + 5] = 1'b1;
    send64_to(b + 48);
    check("t4_m1_state", sync_state64, 2'd2);
    send64_to(b + 64);
    check("t4_m2_state", sync_state64, 2'd2);
    check("t4_m2_loss", sync_loss64, 1'b0);
    send64_to(b + 80);
    check("t4_loss_pulse", sync_loss64, 1'b1);
    check("t4_loss_state", sync_state64, 2'd0);
    check("t4_loss_sof", out_sof64, 1'b1);
    send64_to(b + 81);
    check("t4_loss_end", sync_loss64, 1'b0);
    check("t4_hunt_novalid", out_valid64, 1'b0);

    // 5: lone PSync planted in payload
    do_reset();
    for (int i = 0; i <= 40; i++) begin
      step64((i == 5) ? PSYNC : {56'h0, 8'(i)}, 1'b1);
      check("t5_novalid", out_valid64, 1'b0);
      if (i == 6) check("t5_presync", sync_state64, 2'd1);
      if (i == 21) check("t5_hold_presync", sync_state64, 2'd1);
      if (i == 22) begin
        check("t5_back_hunt", sync_state64, 2'd0);
        check("t5_no_loss", sync_loss64, 1'b0);
      end
    end

    // 6a: reset mid-SYNC, then re-lock
    for (int i = 0; i < 64; i++) corrupt[i] = 1'b0;
    do_reset();
    shift = 0; n = 0;
    send64_to(19);
    check("t6_sync", sync_state64, 2'd2);
    d64 = sh64(20, shift);
    v64 = 1'b1;
    reset_in = 1'b1;
    @(posedge clk);
    #1;
    reset_in = 1'b0;
    n = 21;
    check("t6_rst_state", sync_state64, 2'd0);
    check("t6_rst_valid", out_valid64, 1'b0);
    check("t6_rst_sof", out_sof64, 1'b0);
    check("t6_rst_loss", sync_loss64, 1'b0);
    check("t6_rst_data", out_data64, 64'h0);
    check("t6_rst_sfc", sfc_out64, 51'd0);
    check("t6_rst_offset", bit_offset64, 6'd0);
    send64_to(33);
    check("t6_presync", sync_state64, 2'd1);
    send64_to(48);
    check("t6_hold", sync_state64, 2'd1);
    send64_to(49);
    check("t6_relock", sync_state64, 2'd2);
    check("t6_relock_sof", out_sof64, 1'b1);
    check("t6_relock_data", out_data64, PSYNC);
    send64_to(50);
    check("t6_sfc8", sfc_out64, 51'd8);
    check("t6_sfcv", sfc_valid64, 1'b1);

    // 6b: 128-bit datapath, SFC inside the SOF word
    do_reset();
    n = 0;
    send128_to(1);
    check("w128_presync", sync_state128, 2'd1);
    check("w128_offset", bit_offset128, 7'd0);
    send128_to(17);
    check("w128_sync", sync_state128, 2'd2);
    check("w128_valid", out_valid128, 1'b1);
    check("w128_sof", out_sof128, 1'b1);
    check("w128_sfcv", sfc_valid128, 1'b1);
    check("w128_sfc6", sfc_out128, 51'd6);
    check("w128_data", out_data128, {PSYNC, 51'd6, 13'h0});
    send128_to(18);
    check("w128_sof_off", out_sof128, 1'b0);
    check("w128_sfcv_off", sfc_valid128, 1'b0);
    send128_to(33);
    check("w128_sof2", out_sof128, 1'b1);
    check("w128_sfcv2", sfc_valid128, 1'b1);
    check("w128_sfc7", sfc_out128, 51'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/xg_pon_frame_sync_aligner.md
Name: xg_pon_frame_sync_aligner

Overview:
Parametrised XG-PON downstream frame synchroniser with bit-alignment, the successor to the fixed-width frame-sync stub. It accepts an unaligned serial-derived word stream and hunts for the 64-bit PSync pattern at any bit offset. It runs the HUNT/PRESYNC/SYNC acquisition machine with M1/M2 hysteresis and emits frame-aligned words with a start-of-frame marker and the extracted superframe counter. It sits between the deserialiser/gearbox and the downstream FEC/descrambler path.

Parameters:
DATA_W, 64, datapath width in bits; legal values 64, 128, 256.
FRAME_WORDS, 19440, words per 125 us frame (155520 bytes * 8 / DATA_W); reduced in simulation.
PSYNC, 64'hC5E51840FD59BB49, PSync pattern.
M1, 2, consecutive PSync detections to reach SYNC, including the HUNT detection; minimum 2.
M2, 3, consecutive PSync misses in SYNC before loss of sync; minimum 1.

Ports:
clk_in  in  1  clock
reset_in  in  1  synchronous active-high reset
rx_data_in  in  DATA_W  unaligned input word, MSB first in time
rx_valid_in  in  1  rx_data_in qualifier
out_data  out  DATA_W  bit-aligned frame data
out_valid  out  1  out_data qualifier; SYNC only
out_sof  out  1  out_data word holds the frame's first bit (PSync in its top 64 bits)
sfc_out  out  51  superframe counter from the current frame's PSBd
sfc_valid  out  1  one-cycle strobe; sfc_out updated
sync_state  out  2  0=HUNT, 1=PRESYNC, 2=SYNC
bit_offset  out  log2(DATA_W)  locked alignment offset
sync_loss  out  1  one-cycle pulse on SYNC->HUNT

Behaviour:
- Clock is clk_in; reset_in is synchronous, active-high, and has priority over all other logic.
- Reset values: all outputs 0, sync_state=HUNT, counters and the previous-word register cleared.
- Window W = {prev_word, rx_data_in}, 2*DATA_W bits. Candidate at offset k (0..DATA_W-1) = W[2*DATA_W-1-k -: DATA_W]. Match(k) = top 64 bits of candidate equal PSYNC, exact compare with no error tolerance.
- Nothing advances while rx_valid_in=0. prev_word loads only on valid words.
- HUNT: each valid word, test all DATA_W offsets. On any match, take the lowest k, latch bit_offset=k, set word_cnt=1 and det_cnt=1, then go to PRESYNC.
- word_cnt counts valid words modulo FRAME_WORDS. Boundary word = the word on which word_cnt wraps to 0; only offset bit_offset is tested there.
- PRESYNC: on a boundary match, det_cnt++; when det_cnt reaches M1, go to SYNC. On a boundary miss, go to HUNT with no sync_loss. Non-boundary words are ignored.
- SYNC: on a boundary match, miss_cnt=0. On a boundary miss, miss_cnt++ and continue flywheeling. When miss_cnt reaches M2, go to HUNT and pulse sync_loss. The HUNT search restarts on the next valid word.
- Output path, one register stage: out_data = candidate(bit_offset). out_valid = registered (rx_valid_in and state==SYNC). Latency is 1 cycle from rx_valid_in.
- out_sof = out_valid on a boundary word, asserted even on a PSync miss (flywheel).
- The first out_valid after entering SYNC is the boundary word that completed M1, so out_sof=1 on it.
- SFC field = PSBd bits 64..127; sfc_out = its top 51 bits; HEC is not checked.
  - DATA_W=64: field is the word after the SOF word; sfc_valid is aligned with that out_valid.
  - DATA_W>=128: field is in the SOF word; sfc_valid is coincident with out_sof.
- A match at a non-locked offset during PRESYNC or SYNC is ignored.
- Reset mid-operation returns to HUNT the next cycle, with no sync_loss pulse.
- bit_offset holds its value in HUNT until a new lock.

Test Plan:
1. DATA_W=64, FRAME_WORDS=16, M1=2, M2=3. Clean frames at offset 0, SFC=5,6,7... -> PRESYNC on the first PSync, SYNC at the second. First out_sof one cycle after the second PSync word; sfc_out=6 one word later.
2. Same stream shifted by 17 bits -> bit_offset=17; out_data words bit-exact to the unshifted stream; out_sof every 16 valid words.
3. rx_valid_in toggled 50% random in SYNC -> no loss; out_sof spacing is exactly 16 valid words.
4. In SYNC, corrupt one PSync bit in frames n and n+1, then a clean frame -> stays SYNC, out_sof still asserted, sync_loss=0. Corrupt 3 consecutive PSyncs -> sync_loss pulse on the third; sync_state=0 next cycle.
5. PSync pattern planted in payload at word 5 while in HUNT, with no repeat 16 words later -> PRESYNC, then back to HUNT; out_valid never asserted.
6. reset_in asserted for 1 cycle mid-SYNC -> all outputs 0, sync_state=0 next cycle; re-lock after 2 frames. DATA_W=128 repeat of test 1 -> sfc_valid coincident with out_sof.
